// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control, run/halt state machine and saturating performance counters for a 5-stage Y86-64 core.
// Latency: stall/bubble outputs are same-cycle combinational from the inputs in RUN; state, final_stat and counters update on the next clk edge.
// Backpressure: none; fetch and the pipeline registers obey F_stall/D_stall/W_stall and the bubbles every cycle.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  input  logic             W_valid,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc_en,
  output logic             running,
  output logic             halted,
  output logic [1:0]       final_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [1:0] S_AOK    = 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q;
  logic [1:0]       final_stat_q;
  logic [CNT_W-1:0] cyc_cnt_q, ret_cnt_q, stall_cnt_q, flush_cnt_q;

  logic load_use, ret_any, mispred, exc_m, exc_w;

  // Increment unless already pinned at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return (en && (v != '1)) ? (v + one) : v;
  endfunction

  // Raw hazard conditions decoded from the pipeline registers.
  always_comb begin
    load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_any  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mispred  = (E_icode == I_JXX) && !e_Cnd;
    exc_m    = (m_stat != S_AOK);
    exc_w    = (W_stat != S_AOK);
  end

  // Per-stage control: hazard-driven in RUN, machine frozen in IDLE/HALTED.
  // A load-use hazard coinciding with a ret holds D rather than bubbling it so the load's consumer is not lost.
  always_comb begin
    F_stall   = 1'b1;
    D_stall   = 1'b1;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    W_stall   = 1'b1;
    set_cc_en = 1'b0;
    case (state_q)
      RUN: begin
        F_stall   = load_use || ret_any;
        D_stall   = load_use;
        D_bubble  = mispred || (!load_use && ret_any);
        E_bubble  = mispred || load_use;
        M_bubble  = exc_m || exc_w;
        W_stall   = exc_w;
        set_cc_en = !(exc_m || exc_w);
      end
      HALTED: M_bubble = 1'b1;
      default: ;
    endcase
  end

  // Run/halt sequencing, exit status capture and performance counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      final_stat_q <= S_AOK;
      cyc_cnt_q    <= '0;
      ret_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= RUN;
        RUN: begin
          cyc_cnt_q   <= sat_inc(cyc_cnt_q, 1'b1);
          ret_cnt_q   <= sat_inc(ret_cnt_q, W_valid && (W_stat == S_AOK));
          stall_cnt_q <= sat_inc(stall_cnt_q, F_stall);
          flush_cnt_q <= sat_inc(flush_cnt_q, mispred);
          if (exc_w && W_valid) begin
            state_q      <= HALTED;
            final_stat_q <= W_stat;
          end
        end
        HALTED: state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign running    = (state_q == RUN);
  assign halted     = (state_q == HALTED);
  assign final_stat = final_stat_q;
  assign cyc_cnt    = cyc_cnt_q;
  assign ret_cnt    = ret_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, nop run, load-use, ret, combined hazards, mispredict, halt, saturation.
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 units after that edge.
// Counters are narrowed to 5 bits so saturation is reachable in a few dozen cycles.
module tb_pipe_hazard_ctrl;
  localparam int W = 5;

  logic clk = 1'b0;
  logic reset, start, e_Cnd, W_valid;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic [1:0] m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, running, halted;
  logic [1:0] final_stat;
  logic [W-1:0] cyc_cnt, ret_cnt, stall_cnt, flush_cnt;

  int checks = 0;
  int passes = 0;

  pipe_hazard_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .W_valid(W_valid),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc_en(set_cc_en),
    .running(running), .halted(halted), .final_stat(final_stat),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en}
  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {25'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en}, {25'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nops();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
    m_stat = 2'b00; W_stat = 2'b00;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; W_valid = 1'b0;
    nops();
    step(); step();
    reset = 1'b0;
    // Reset / IDLE
    chk_ctl("idle_ctl", 7'b1100010);
    chk("idle_run", {30'd0, running, halted}, 32'd0);
    chk("idle_cnts", {12'd0, cyc_cnt, ret_cnt, stall_cnt, flush_cnt}, 32'd0);
    chk("idle_fstat", {30'd0, final_stat}, 32'd0);

    start = 1'b1; step(); start = 1'b0;
    chk("run_entry", {30'd0, running, halted}, 32'd2);

    // 10 retiring nops
    W_valid = 1'b1;
    repeat (10) step();
    chk_ctl("nop_ctl", 7'b0000001);
    chk("nop_cyc", {27'd0, cyc_cnt}, 32'd10);
    chk("nop_ret", {27'd0, ret_cnt}, 32'd10);
    W_valid = 1'b0;

    // Load-use via srcA
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    chk_ctl("lu_ctl", 7'b1101001);
    step();
    chk("lu_stallcnt", {27'd0, stall_cnt}, 32'd1);

    // dstM = none must not match srcA = none
    E_dstM = 4'hF; d_srcA = 4'hF;
    chk_ctl("lu_none_ctl", 7'b0000001);

    // ret walking through D, E, M
    nops(); D_icode = 4'h9;
    chk_ctl("ret_d_ctl", 7'b1010001);
    step();
    nops(); E_icode = 4'h9;
    chk_ctl("ret_e_ctl", 7'b1010001);
    step();
    nops(); M_icode = 4'h9;
    chk_ctl("ret_m_ctl", 7'b1010001);
    step();
    chk("ret_stallcnt", {27'd0, stall_cnt}, 32'd4);

    // popq load-use on srcB together with ret in M
    nops(); E_icode = 4'hB; E_dstM = 4'h3; d_srcB = 4'h3; M_icode = 4'h9;
    chk_ctl("lu_ret_ctl", 7'b1101001);
    step();

    // jXX taken: no flush; not taken: flush
    nops(); E_icode = 4'h7; e_Cnd = 1'b1;
    chk_ctl("jxx_taken_ctl", 7'b0000001);
    e_Cnd = 1'b0;
    chk_ctl("mispred_ctl", 7'b0011001);
    step();
    chk("flush_cnt", {27'd0, flush_cnt}, 32'd1);

    // start while running is ignored
    nops(); start = 1'b1; step(); start = 1'b0;
    chk("start_in_run", {30'd0, running, halted}, 32'd2);

    // Memory exception, then writeback exception halts
    m_stat = 2'b10;
    chk_ctl("exc_m_ctl", 7'b0000100);
    step();
    m_stat = 2'b00; W_stat = 2'b10; W_valid = 1'b1;
    chk_ctl("exc_w_ctl", 7'b0000110);
    step();
    chk("halt_state", {30'd0, running, halted}, 32'd1);
    chk("halt_fstat", {30'd0, final_stat}, 32'd2);
    chk_ctl("halt_ctl", 7'b1100110);
    nops(); start = 1'b1; step(); step(); start = 1'b0;
    chk("halt_sticky", {30'd0, running, halted}, 32'd1);
    chk("halt_cnts", {12'd0, cyc_cnt, ret_cnt, stall_cnt, flush_cnt}, {12'd0, 5'd19, 5'd10, 5'd5, 5'd1});

    // Reset exits HALTED
    reset = 1'b1; step(); reset = 1'b0;
    chk("reset_state", {30'd0, running, halted}, 32'd0);
    chk("reset_cnts", {12'd0, cyc_cnt, ret_cnt, stall_cnt, flush_cnt}, 32'd0);
    chk("reset_fstat", {30'd0, final_stat}, 32'd0);

    // Saturation: 35 RUN cycles into a 5-bit counter
    start = 1'b1; step(); start = 1'b0;
    W_valid = 1'b1;
    repeat (35) step();
    chk("sat_cyc", {27'd0, cyc_cnt}, 32'd31);
    chk("sat_ret", {27'd0, ret_cnt}, 32'd31);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
